// File: rtl/bp_be_fe_queue_skid_pkg.sv
// Package for the FE->BE queue skid buffer.
//  - bp_params_e          : processor configuration selector
//  - bp_fe_queue_s        : FE queue packet (pc, instr, partial, branch_metadata_fwd, msg_type)
//  - bp_be_fe_skid_state_e: skid buffer occupancy state (empty/one/two)
//  - bp_fe_queue_width()  : FE queue packet width for a given configuration
//  - skid_occupancy()     : number of packets held in a given skid state
package bp_be_fe_queue_skid_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_unicore_cfg = 2'd1
  } bp_params_e;

  localparam int vaddr_width_gp               = 39;
  localparam int instr_width_gp               = 32;
  localparam int branch_metadata_fwd_width_gp = 40;

  typedef struct packed {
    logic [1:0]                              msg_type;
    logic [vaddr_width_gp-1:0]               pc;
    logic [instr_width_gp-1:0]               instr;
    logic                                    partial;
    logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
  } bp_fe_queue_s;

  // Encoding equals the number of held packets.
  typedef enum logic [1:0] {
    e_skid_empty = 2'd0,
    e_skid_one   = 2'd1,
    e_skid_two   = 2'd2
  } bp_be_fe_skid_state_e;

  // Every supported configuration shares the same FE queue packet format.
  function automatic int bp_fe_queue_width(bp_params_e cfg);
    if (cfg inside {e_bp_default_cfg, e_bp_unicore_cfg})
      return $bits(bp_fe_queue_s);
    else
      return $bits(bp_fe_queue_s);
  endfunction

  function automatic logic [1:0] skid_occupancy(bp_be_fe_skid_state_e s);
    case (s)
      e_skid_one: return 2'd1;
      e_skid_two: return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_skid_sat_ctr.sv
// Saturating up-counter used for the skid buffer perf counters.
//  clk_i      in  clock
//  reset_n_i  in  asynchronous reset, active low (clears the count)
//  incr_i     in  amount to add this cycle (0..3)
//  count_o    out current count, sticks at all-ones
module bp_be_fe_skid_sat_ctr #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [1:0]         incr_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r;
  logic [width_p:0]   sum;

  // One extra bit catches the carry out that triggers saturation.
  assign sum = {1'b0, count_r} + {{(width_p-1){1'b0}}, incr_i};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)        count_r <= '0;
    else if (sum[width_p]) count_r <= '1;
    else                   count_r <= sum[width_p-1:0];
  end

  assign count_o = count_r;

endmodule

// File: rtl/bp_be_fe_queue_skid.sv
// Two-entry registered skid buffer between the FE queue and the BE issue queue.
// Breaks the combinational ready path: fe_queue_ready_and_o comes from a flop,
// so issue-queue full/suppress logic never reaches FE. One cycle latency, no
// bypass, strict FIFO order, payload untouched. clr_v_i drops everything held
// plus any packet accepted in the same cycle; a deq in that cycle completes.
//
// Ports
//  clk_i, reset_n_i          clock, async active-low reset
//  clr_v_i                   synchronous flush
//  fe_queue_i / _v_i         packet in from FE, valid
//  fe_queue_ready_and_o      skid can accept (registered)
//  fe_queue_o / _v_o         head packet to issue queue, valid
//  fe_queue_ready_and_i      issue queue accepts
//  stall_cnt_o, flush_cnt_o  perf counters, live only with BP_BE_FE_SKID_PERF_EN
//
// Optional feature macro: BP_BE_FE_SKID_PERF_EN (saturating perf counters;
// when undefined the counter ports are tied to zero).
module bp_be_fe_queue_skid
  import bp_be_fe_queue_skid_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int         ctr_width_p = 32,
  localparam int        fe_queue_width_lp = bp_fe_queue_width(bp_params_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         clr_v_i,

  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_and_o,

  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_ready_and_i,

  output logic [ctr_width_p-1:0]       stall_cnt_o,
  output logic [ctr_width_p-1:0]       flush_cnt_o
);

  bp_fe_queue_s fe_queue_cast_i, fe_queue_cast_o;
  assign fe_queue_cast_i = fe_queue_i;

  bp_be_fe_skid_state_e state_r, state_n;
  logic                 head_r, tail_r, head_n, tail_n;
  // Registered copies of (state != two) and (state != empty); ready_r is also
  // held low while reset is asserted.
  logic                 ready_r, v_r;
  logic                 enq, deq;

  bp_fe_queue_s mem_r [2];

  assign enq = fe_queue_v_i & ready_r;
  assign deq = v_r & fe_queue_ready_and_i;

  always_comb begin
    state_n = state_r;
    head_n  = head_r ^ deq;
    tail_n  = tail_r ^ enq;
    unique case (state_r)
      e_skid_empty: if (enq) state_n = e_skid_one;
      e_skid_one: begin
        if (enq & ~deq)      state_n = e_skid_two;
        else if (deq & ~enq) state_n = e_skid_empty;
      end
      // enq cannot happen here: ready_r is low in two.
      e_skid_two:   if (deq) state_n = e_skid_one;
      default:      state_n = e_skid_empty;
    endcase
    if (clr_v_i) begin
      state_n = e_skid_empty;
      head_n  = 1'b0;
      tail_n  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_skid_empty;
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      ready_r <= 1'b0;
      v_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      head_r  <= head_n;
      tail_r  <= tail_n;
      ready_r <= (state_n != e_skid_two);
      v_r     <= (state_n != e_skid_empty);
    end
  end

  // Payload storage has no reset; it is only observed while v_r is set.
  always_ff @(posedge clk_i) begin
    if (enq & ~clr_v_i) mem_r[tail_r] <= fe_queue_cast_i;
  end

  assign fe_queue_cast_o      = mem_r[head_r];
  assign fe_queue_o           = fe_queue_cast_o;
  assign fe_queue_v_o         = v_r;
  assign fe_queue_ready_and_o = ready_r;

`ifdef BP_BE_FE_SKID_PERF_EN
  logic [1:0] stall_incr, flush_incr;

  assign stall_incr = {1'b0, fe_queue_v_i & ~ready_r};
  // Packets lost to a flush: held ones, minus the one leaving, plus the one arriving.
  assign flush_incr = clr_v_i
                    ? (skid_occupancy(state_r) - {1'b0, deq} + {1'b0, enq})
                    : 2'b00;

  bp_be_fe_skid_sat_ctr #(.width_p(ctr_width_p)) stall_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .incr_i   (stall_incr),
    .count_o  (stall_cnt_o)
  );

  bp_be_fe_skid_sat_ctr #(.width_p(ctr_width_p)) flush_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .incr_i   (flush_incr),
    .count_o  (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_skid.sv
// Scoreboard bench for bp_be_fe_queue_skid. Accepted packets are queued as
// expected output; a negedge monitor pops and compares on every deq.
module tb_bp_be_fe_queue_skid;
  import bp_be_fe_queue_skid_pkg::*;

  localparam int W  = bp_fe_queue_width(e_bp_default_cfg);
  localparam int CW = 4;
`ifdef BP_BE_FE_SKID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, clr, v_i, ready_o, v_o, ready_i;
  logic [W-1:0]  fe_in, fe_out;
  logic [CW-1:0] stall_cnt, flush_cnt;

  bp_be_fe_queue_skid #(.bp_params_p(e_bp_default_cfg), .ctr_width_p(CW)) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .clr_v_i             (clr),
    .fe_queue_i          (fe_in),
    .fe_queue_v_i        (v_i),
    .fe_queue_ready_and_o(ready_o),
    .fe_queue_o          (fe_out),
    .fe_queue_v_o        (v_o),
    .fe_queue_ready_and_i(ready_i),
    .stall_cnt_o         (stall_cnt),
    .flush_cnt_o         (flush_cnt)
  );

  always #5 clk = ~clk;

  int           errs = 0, checks = 0, n_pop = 0;
  bp_fe_queue_s sb[$];
  logic         last_acc;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bp_fe_queue_s mk(input logic [38:0] pc, input logic [31:0] instr);
    bp_fe_queue_s p;
    p.msg_type            = instr[2:1];
    p.pc                  = pc;
    p.instr               = instr;
    p.partial             = instr[0];
    p.branch_metadata_fwd = {8'hA5, ~instr};
    return p;
  endfunction

  // Monitor: every deq must match the oldest accepted packet.
  always @(negedge clk) begin
    if (reset_n && v_o && ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", fe_out, '0);
      end else begin
        bp_fe_queue_s e;
        e = sb.pop_front();
        n_pop++;
        chk("sb_data", fe_out, e);
      end
    end
  end

  // One cycle of stimulus; starts and ends just after a posedge. Bookkeeping
  // runs after the monitor (negedge + 1) so a deq in a clr cycle is popped first.
  task automatic step_in(input logic v, input bp_fe_queue_s p, input logic rdy, input logic c);
    v_i = v; fe_in = p; ready_i = rdy; clr = c;
    @(negedge clk); #1;
    last_acc = v && ready_o;
    if (c) sb.delete();
    else if (last_acc) sb.push_back(p);
    @(posedge clk); #1;
  endtask

  bp_fe_queue_s idle;
  logic         ok;
  int           nacc;

  initial begin
    idle = mk(39'h0, 32'h0);
    // Test 1: reset held with v_i=1
    reset_n = 1'b0; clr = 1'b0; ready_i = 1'b0; v_i = 1'b1;
    fe_in = mk(39'h7f00, 32'h1111_0001);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_v", v_o, 1'b0);
    chk("rst_stall", stall_cnt, '0);
    chk("rst_flush", flush_cnt, '0);
    v_i = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", ready_o, 1'b1);
    chk("rel_v", v_o, 1'b0);

    // Test 2: latency and pass-through
    step_in(1'b1, mk(39'h80000000, 32'h0000_0013), 1'b1, 1'b0);
    chk("lat_acc", last_acc, 1'b1);
    chk("lat_v1", v_o, 1'b1);
    chk("lat_data", fe_out, mk(39'h80000000, 32'h0000_0013));
    step_in(1'b0, idle, 1'b1, 1'b0);
    chk("lat_v0", v_o, 1'b0);

    // Test 3: backpressure fill then drain A, B, C
    step_in(1'b1, mk(39'h100, 32'hAAAA_0001), 1'b0, 1'b0);
    step_in(1'b1, mk(39'h104, 32'hBBBB_0002), 1'b0, 1'b0);
    chk("bp_ready_full", ready_o, 1'b0);
    chk("bp_head_a", fe_out, mk(39'h100, 32'hAAAA_0001));
    step_in(1'b1, mk(39'h108, 32'hCCCC_0003), 1'b0, 1'b0);
    chk("bp_c_held", last_acc, 1'b0);
    chk("bp_stall1", stall_cnt, PERF ? 4'd1 : 4'd0);
    step_in(1'b1, mk(39'h108, 32'hCCCC_0003), 1'b0, 1'b0);
    chk("bp_stall2", stall_cnt, PERF ? 4'd2 : 4'd0);
    chk("bp_head_stable", fe_out, mk(39'h100, 32'hAAAA_0001));
    step_in(1'b1, mk(39'h108, 32'hCCCC_0003), 1'b1, 1'b0);   // A leaves, C still held
    step_in(1'b1, mk(39'h108, 32'hCCCC_0003), 1'b1, 1'b0);   // C in, B leaves
    chk("bp_c_acc", last_acc, 1'b1);
    step_in(1'b0, idle, 1'b1, 1'b0);                          // C leaves
    chk("bp_empty", v_o, 1'b0);
    chk("bp_stall3", stall_cnt, PERF ? 4'd3 : 4'd0);

    // Test 4: 16-packet stream at full rate
    ok = 1'b1; nacc = 0;
    for (int i = 0; i < 16; i++) begin
      step_in(1'b1, mk(39'h2000 + 39'(i * 4), 32'h5EED_0000 ^ 32'(i * 32'h0101_0107)), 1'b1, 1'b0);
      if (last_acc) nacc++;
      if (!(v_o && ready_o)) ok = 1'b0;
    end
    chk("stream_acc", nacc, 16);
    chk("stream_state_one", ok, 1'b1);
    step_in(1'b0, idle, 1'b1, 1'b0);
    chk("stream_drain", v_o, 1'b0);

    // Test 5: flush from two, from one with enq+deq, from empty with enq
    step_in(1'b1, mk(39'h300, 32'hD0D0_0004), 1'b0, 1'b0);
    step_in(1'b1, mk(39'h304, 32'hE0E0_0005), 1'b0, 1'b0);
    chk("fl_full", ready_o, 1'b0);
    step_in(1'b1, mk(39'h308, 32'hF0F0_0006), 1'b0, 1'b1);
    chk("fl2_v", v_o, 1'b0);
    chk("fl2_ready", ready_o, 1'b1);
    chk("fl2_cnt", flush_cnt, PERF ? 4'd2 : 4'd0);
    chk("fl2_stall", stall_cnt, PERF ? 4'd4 : 4'd0);
    step_in(1'b1, mk(39'h30c, 32'h6060_0007), 1'b0, 1'b0);
    step_in(1'b1, mk(39'h310, 32'h7070_0008), 1'b1, 1'b1);  // G leaves, H dropped
    chk("fl1_v", v_o, 1'b0);
    chk("fl1_cnt", flush_cnt, PERF ? 4'd3 : 4'd0);
    step_in(1'b1, mk(39'h314, 32'h8080_0009), 1'b0, 1'b1);  // I dropped from empty
    chk("fl0_v", v_o, 1'b0);
    chk("fl0_cnt", flush_cnt, PERF ? 4'd4 : 4'd0);

    // Test 6: stall counter saturation (4 so far)
    step_in(1'b1, mk(39'h400, 32'h1234_000A), 1'b0, 1'b0);
    step_in(1'b1, mk(39'h404, 32'h1234_000B), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step_in(1'b1, mk(39'h408, 32'h1234_000C), 1'b0, 1'b0);
    chk("sat_mid", stall_cnt, PERF ? 4'hE : 4'h0);
    for (int i = 0; i < 10; i++) step_in(1'b1, mk(39'h408, 32'h1234_000C), 1'b0, 1'b0);
    chk("sat_full", stall_cnt, PERF ? 4'hF : 4'h0);
    chk("sat_head", fe_out, mk(39'h400, 32'h1234_000A));
    step_in(1'b0, idle, 1'b0, 1'b1);
    chk("sat_flush", flush_cnt, PERF ? 4'd6 : 4'd0);
    chk("sat_stall_hold", stall_cnt, PERF ? 4'hF : 4'h0);

    repeat (3) step_in(1'b0, idle, 1'b1, 1'b0);
    chk("end_v", v_o, 1'b0);
    chk("sb_drained", sb.size(), 0);
    chk("pop_count", n_pop, 21);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
